bounce_shift_gen: RTL and testbench
===================================

// Module: bounce_shift_gen
// PURPOSE
//   Parametrised successor to the 8-bit bouncing one-hot shift counter.
//   - Walks a group of TAIL contiguous ones across a WIDTH-bit vector.
//   - Run-time modes: bounce, rotate-left, rotate-right and hold.
//   - A prescaler sets the step rate; an enable gates it; a synchronous clear restarts the pattern.
//   - Drives LED/scan-style pattern outputs and signals end-of-sweep events to a controller.
// PARAMETERS
//   WIDTH     8   vector width, >= 2
//   TAIL      1   number of lit bits in the walking group, 1..WIDTH-1
//   PRESCALE  1   enabled clock cycles per step, >= 1 (1 = step every enabled cycle)
// PORTS
//   clk       in   1      single clock, rising edge
//   reset     in   1      asynchronous, active-low (0 = reset asserted)
//   en        in   1      step enable; 0 freezes all state, including the prescaler
//   clr       in   1      synchronous restart to the reset state; has priority over en
//   mode      in   2      00 bounce, 01 rotate-left, 10 rotate-right, 11 hold
//   counter   out  WIDTH  registered pattern output
//   dir       out  1      1 = moving toward the MSB, 0 = moving toward the LSB
//   edge_hit  out  1      one-cycle pulse on the cycle the step reaches an end or wraps
// BEHAVIOUR
//   State
//   - pos: POS_W = $clog2(WIDTH) bits. dir: 1 bit. tick: prescaler, $clog2(PRESCALE) bits (min 1).
//   - counter = rotl({(WIDTH-TAIL)'b0, TAIL'b1}, pos). It is registered and updated on the same
//     edge as pos, never combinational.
//   Reset (reset==0, asynchronous) and clr==1 (synchronous) give the same state:
//     pos=0, dir=1, tick=0, counter={TAIL ones in the LSBs}, edge_hit=0.
//   Step
//   - step = en && (tick==PRESCALE-1) && mode!=11.
//   - tick increments while en && mode!=11 and wraps to 0 on step.
//   - When en==0 or mode==11, tick, pos and dir hold and edge_hit=0.
//   - Latency: with PRESCALE=1, counter changes on every enabled edge.
//   Bounce (00); MAXP = WIDTH-TAIL
//   - Moving up (dir=1): pos+1. If the new pos==MAXP: dir<=0, edge_hit<=1.
//   - Moving down (dir=0): pos-1. If the new pos==0: dir<=1, edge_hit<=1.
//   - Clamp: if pos>MAXP on the step (after leaving rotate mode): pos<=MAXP, dir<=0, edge_hit<=1.
//   - End positions are visited once, so the period is 2*MAXP steps.
//     WIDTH=8, TAIL=1 gives 01,02..80,40..01,02.
//   Rotate-left (01)
//   - pos <= (pos==WIDTH-1) ? 0 : pos+1. dir<=1.
//   - edge_hit=1 on the wrap WIDTH-1 -> 0. The ones group wraps across the MSB/LSB boundary.
//   Rotate-right (10)
//   - pos <= (pos==0) ? WIDTH-1 : pos-1. dir<=0.
//   - edge_hit=1 on the wrap 0 -> WIDTH-1.
//   Mode changes
//   - Sampled every cycle; the new mode governs the next step.
//   - pos and tick are preserved across a mode change (no restart).
//   edge_hit
//   - Registered. Asserted for exactly the one cycle after the stepping edge.
//   - Low whenever no step occurs.
//   Reset during operation
//   - Asserting reset mid-sweep or mid-prescale forces the reset state immediately.
//   - The first step after release occurs PRESCALE enabled cycles later.
// STRUCTURE
//   Shared package bounce_shift_pkg
//   - Mode constants: MODE_BOUNCE=2'b00, MODE_ROTL=2'b01, MODE_ROTR=2'b10, MODE_HOLD=2'b11.
//   - DIR_UP=1'b1.
//   Sub-module step_prescaler
//   - Parameter PRESCALE. Ports clk, reset, clr, run (= en && mode!=HOLD), step out.
//   - The top level holds the pos/dir update logic and the pattern register.
// TESTING (WIDTH=8 unless stated)
//   1 TAIL=1, PRESCALE=1, mode=00, en=1 for 16 cycles after reset
//     -> counter 01,02,04..80,40..01,02; edge_hit on 80 and on 01; dir drops on 80.
//   2 TAIL=3, mode=00 -> 07,0E,1C,38,70,E0(edge_hit,dir=0),70..07(edge_hit),0E.
//   3 TAIL=3, mode=01 from pos=5 (E0) -> C1,83,07(edge_hit); mode=10 from 07 -> 83(edge_hit),C1.
//   4 PRESCALE=4, mode=00, en toggled 1,1,0,1,1 -> first step on the 4th enabled cycle;
//     counter holds while en=0.
//   5 mode=01 until pos=7 (TAIL=1, counter=80), then mode=00
//     -> pos clamps to 7, dir=0, edge_hit; next step gives 40.
//   6 Async reset asserted mid-sweep and between clock edges -> counter=01, dir=1 immediately;
//     clr=1 with en=1 -> reset state on the next edge.

Source files
------------

// File: rtl/bounce_shift_pkg.sv
// rtl/bounce_shift_pkg.sv - shared constants for the bouncing shift pattern generator
// Purpose: mode encodings and direction constant used by the generator and its bench.
// Ports: none (package).
package bounce_shift_pkg;

  localparam logic [1:0] MODE_BOUNCE = 2'b00;
  localparam logic [1:0] MODE_ROTL   = 2'b01;
  localparam logic [1:0] MODE_ROTR   = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  localparam logic DIR_UP = 1'b1;

endpackage

// File: rtl/bounce_shift_gen_if.sv
// rtl/bounce_shift_gen_if.sv - control/pattern bundle between controller and generator
// Purpose: groups the step controls and the pattern/event outputs.
// Ports:
//   en, clr, mode          controller -> generator
//   counter, dir, edge_hit generator -> controller
interface bounce_shift_gen_if #(
  parameter int WIDTH = 8
);
  logic             en;
  logic             clr;
  logic [1:0]       mode;
  logic [WIDTH-1:0] counter;
  logic             dir;
  logic             edge_hit;

  modport master (
    output en, clr, mode,
    input  counter, dir, edge_hit
  );

  modport slave (
    input  en, clr, mode,
    output counter, dir, edge_hit
  );
endinterface

// File: rtl/bounce_shift_gen_step_prescaler.sv
// rtl/bounce_shift_gen_step_prescaler.sv - divides enabled cycles into step strobes
// Purpose: counts cycles while run is high and raises step on every PRESCALE-th one.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset
//   clr    in  synchronous restart of the count
//   run    in  count enable (en && mode != hold)
//   step   out combinational strobe, high on the last cycle of each prescale period
module step_prescaler #(
  parameter int PRESCALE = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic run,
  output logic step
);

  localparam int TW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
  localparam logic [TW-1:0] LAST = TW'(PRESCALE - 1);

  logic [TW-1:0] tick;

  // With PRESCALE=1 LAST is 0 and tick never leaves 0, so step follows run.
  assign step = run && (tick == LAST);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      tick <= '0;
    end else if (clr) begin
      tick <= '0;
    end else if (run) begin
      tick <= step ? '0 : tick + TW'(1);
    end
  end

endmodule

// File: rtl/bounce_shift_gen.sv
// rtl/bounce_shift_gen.sv - walking ones-group pattern generator (bounce/rotate/hold)
// Purpose: moves a group of TAIL ones across a WIDTH-bit vector at a prescaled rate.
// Ports:
//   clk    in  clock, rising edge
//   reset  in  asynchronous active-low reset
//   bus    slave side of bounce_shift_gen_if:
//          en/clr/mode in; counter/dir/edge_hit out, all registered
module bounce_shift_gen
  import bounce_shift_pkg::*;
#(
  parameter int WIDTH    = 8,
  parameter int TAIL     = 1,
  parameter int PRESCALE = 1
) (
  input  logic              clk,
  input  logic              reset,
  bounce_shift_gen_if.slave bus
);

  localparam int POS_W = $clog2(WIDTH);
  localparam logic [POS_W-1:0] MAXP  = POS_W'(WIDTH - TAIL);
  localparam logic [POS_W-1:0] LASTP = POS_W'(WIDTH - 1);
  localparam logic [WIDTH-1:0] BASE  = {{(WIDTH-TAIL){1'b0}}, {TAIL{1'b1}}};

  logic [POS_W-1:0] pos;
  logic             dir;
  logic [WIDTH-1:0] counter;
  logic             edge_hit;

  logic [POS_W-1:0] nxt_pos;
  logic             nxt_dir;
  logic             nxt_hit;
  logic             run;
  logic             step;

  // Rotate-left of the base group: the upper half of the doubled word
  // picks up the bits that spill past the MSB.
  function automatic logic [WIDTH-1:0] pattern(input logic [POS_W-1:0] p);
    logic [2*WIDTH-1:0] d;
    d = {BASE, BASE} << p;
    return d[2*WIDTH-1:WIDTH];
  endfunction

  assign run = bus.en && (bus.mode != MODE_HOLD);

  step_prescaler #(
    .PRESCALE (PRESCALE)
  ) u_prescaler (
    .clk   (clk),
    .reset (reset),
    .clr   (bus.clr),
    .run   (run),
    .step  (step)
  );

  always_comb begin
    nxt_pos = pos;
    nxt_dir = dir;
    nxt_hit = 1'b0;
    case (bus.mode)
      MODE_BOUNCE: begin
        // Arriving from a rotate mode can leave pos at or beyond the top
        // end while still heading up; fold back to the end and turn.
        if (pos > MAXP || (dir == DIR_UP && pos == MAXP)) begin
          nxt_pos = MAXP;
          nxt_dir = ~DIR_UP;
          nxt_hit = 1'b1;
        end else if (dir != DIR_UP && pos == '0) begin
          nxt_dir = DIR_UP;
          nxt_hit = 1'b1;
        end else if (dir == DIR_UP) begin
          nxt_pos = pos + POS_W'(1);
          if (nxt_pos == MAXP) begin
            nxt_dir = ~DIR_UP;
            nxt_hit = 1'b1;
          end
        end else begin
          nxt_pos = pos - POS_W'(1);
          if (nxt_pos == '0) begin
            nxt_dir = DIR_UP;
            nxt_hit = 1'b1;
          end
        end
      end
      MODE_ROTL: begin
        nxt_dir = DIR_UP;
        if (pos == LASTP) begin
          nxt_pos = '0;
          nxt_hit = 1'b1;
        end else begin
          nxt_pos = pos + POS_W'(1);
        end
      end
      MODE_ROTR: begin
        nxt_dir = ~DIR_UP;
        if (pos == '0) begin
          nxt_pos = LASTP;
          nxt_hit = 1'b1;
        end else begin
          nxt_pos = pos - POS_W'(1);
        end
      end
      default: begin
        nxt_pos = pos;
        nxt_dir = dir;
        nxt_hit = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pos      <= '0;
      dir      <= DIR_UP;
      counter  <= BASE;
      edge_hit <= 1'b0;
    end else if (bus.clr) begin
      pos      <= '0;
      dir      <= DIR_UP;
      counter  <= BASE;
      edge_hit <= 1'b0;
    end else if (step) begin
      pos      <= nxt_pos;
      dir      <= nxt_dir;
      counter  <= pattern(nxt_pos);
      edge_hit <= nxt_hit;
    end else begin
      edge_hit <= 1'b0;
    end
  end

  assign bus.counter  = counter;
  assign bus.dir      = dir;
  assign bus.edge_hit = edge_hit;

endmodule

// File: tb/tb_bounce_shift_gen.sv
// tb/tb_bounce_shift_gen.sv - bench for bounce_shift_gen across three parameter sets
module tb_bounce_shift_gen;
  import bounce_shift_pkg::*;

  typedef struct {
    int         sel;   // 0: TAIL=1 P=1, 1: TAIL=3 P=1, 2: TAIL=1 P=4
    logic       en;
    logic       clr;
    logic [1:0] mode;
    logic [7:0] cnt;
    logic       dir;
    logic       hit;
  } vec_t;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  int   vidx;
  vec_t tbl[$];
  vec_t exp_q[$];

  bounce_shift_gen_if #(.WIDTH(8)) if_a ();
  bounce_shift_gen_if #(.WIDTH(8)) if_b ();
  bounce_shift_gen_if #(.WIDTH(8)) if_c ();

  bounce_shift_gen #(.WIDTH(8), .TAIL(1), .PRESCALE(1)) dut_a (.clk(clk), .reset(reset), .bus(if_a));
  bounce_shift_gen #(.WIDTH(8), .TAIL(3), .PRESCALE(1)) dut_b (.clk(clk), .reset(reset), .bus(if_b));
  bounce_shift_gen #(.WIDTH(8), .TAIL(1), .PRESCALE(4)) dut_c (.clk(clk), .reset(reset), .bus(if_c));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic void add(input int sel, input logic en, input logic clr, input logic [1:0] mode,
                              input logic [7:0] cnt, input logic dir, input logic hit);
    vec_t v;
    v.sel = sel; v.en = en; v.clr = clr; v.mode = mode;
    v.cnt = cnt; v.dir = dir; v.hit = hit;
    tbl.push_back(v);
  endfunction

  task automatic drive(input vec_t v);
    if_a.en = 1'b0; if_a.clr = 1'b0; if_a.mode = MODE_BOUNCE;
    if_b.en = 1'b0; if_b.clr = 1'b0; if_b.mode = MODE_BOUNCE;
    if_c.en = 1'b0; if_c.clr = 1'b0; if_c.mode = MODE_BOUNCE;
    case (v.sel)
      0: begin if_a.en = v.en; if_a.clr = v.clr; if_a.mode = v.mode; end
      1: begin if_b.en = v.en; if_b.clr = v.clr; if_b.mode = v.mode; end
      default: begin if_c.en = v.en; if_c.clr = v.clr; if_c.mode = v.mode; end
    endcase
  endtask

  task automatic apply(input vec_t v);
    vec_t       e;
    logic [7:0] c;
    logic       d;
    logic       h;
    @(negedge clk);
    drive(v);
    exp_q.push_back(v);
    @(posedge clk);
    #1;
    e = exp_q.pop_front();
    case (e.sel)
      0:       begin c = if_a.counter; d = if_a.dir; h = if_a.edge_hit; end
      1:       begin c = if_b.counter; d = if_b.dir; h = if_b.edge_hit; end
      default: begin c = if_c.counter; d = if_c.dir; h = if_c.edge_hit; end
    endcase
    check($sformatf("v%0d.d%0d counter", vidx, e.sel), c, e.cnt);
    check($sformatf("v%0d.d%0d dir", vidx, e.sel), {7'b0, d}, {7'b0, e.dir});
    check($sformatf("v%0d.d%0d edge_hit", vidx, e.sel), {7'b0, h}, {7'b0, e.hit});
    vidx++;
  endtask

  task automatic run1(input int sel, input logic en, input logic clr, input logic [1:0] mode,
                      input logic [7:0] cnt, input logic dir, input logic hit);
    vec_t v;
    v.sel = sel; v.en = en; v.clr = clr; v.mode = mode;
    v.cnt = cnt; v.dir = dir; v.hit = hit;
    apply(v);
  endtask

  initial begin
    total = 0;
    bad   = 0;
    vidx  = 0;

    // Bounce, TAIL=1: up to 80 (turn), down to 01 (turn), on to 04.
    add(0,1,0,MODE_BOUNCE,8'h02,1,0); add(0,1,0,MODE_BOUNCE,8'h04,1,0);
    add(0,1,0,MODE_BOUNCE,8'h08,1,0); add(0,1,0,MODE_BOUNCE,8'h10,1,0);
    add(0,1,0,MODE_BOUNCE,8'h20,1,0); add(0,1,0,MODE_BOUNCE,8'h40,1,0);
    add(0,1,0,MODE_BOUNCE,8'h80,0,1); add(0,1,0,MODE_BOUNCE,8'h40,0,0);
    add(0,1,0,MODE_BOUNCE,8'h20,0,0); add(0,1,0,MODE_BOUNCE,8'h10,0,0);
    add(0,1,0,MODE_BOUNCE,8'h08,0,0); add(0,1,0,MODE_BOUNCE,8'h04,0,0);
    add(0,1,0,MODE_BOUNCE,8'h02,0,0); add(0,1,0,MODE_BOUNCE,8'h01,1,1);
    add(0,1,0,MODE_BOUNCE,8'h02,1,0); add(0,1,0,MODE_BOUNCE,8'h04,1,0);
    // Bounce, TAIL=3: ends at E0 and 07.
    add(1,1,0,MODE_BOUNCE,8'h0E,1,0); add(1,1,0,MODE_BOUNCE,8'h1C,1,0);
    add(1,1,0,MODE_BOUNCE,8'h38,1,0); add(1,1,0,MODE_BOUNCE,8'h70,1,0);
    add(1,1,0,MODE_BOUNCE,8'hE0,0,1); add(1,1,0,MODE_BOUNCE,8'h70,0,0);
    add(1,1,0,MODE_BOUNCE,8'h38,0,0); add(1,1,0,MODE_BOUNCE,8'h1C,0,0);
    add(1,1,0,MODE_BOUNCE,8'h0E,0,0); add(1,1,0,MODE_BOUNCE,8'h07,1,1);
    add(1,1,0,MODE_BOUNCE,8'h0E,1,0);
    // TAIL=3: climb to E0, rotate left across the MSB, then rotate right back.
    add(1,1,0,MODE_BOUNCE,8'h1C,1,0); add(1,1,0,MODE_BOUNCE,8'h38,1,0);
    add(1,1,0,MODE_BOUNCE,8'h70,1,0); add(1,1,0,MODE_BOUNCE,8'hE0,0,1);
    add(1,1,0,MODE_ROTL,  8'hC1,1,0); add(1,1,0,MODE_ROTL,  8'h83,1,0);
    add(1,1,0,MODE_ROTL,  8'h07,1,1); add(1,1,0,MODE_ROTR,  8'h83,0,1);
    add(1,1,0,MODE_ROTR,  8'hC1,0,0); add(1,1,0,MODE_HOLD,  8'hC1,0,0);
    add(1,1,0,MODE_HOLD,  8'hC1,0,0); add(1,1,1,MODE_ROTL,  8'h07,1,0);
    // PRESCALE=4 with en 1,1,0,1,1, then another full period.
    add(2,1,0,MODE_BOUNCE,8'h01,1,0); add(2,1,0,MODE_BOUNCE,8'h01,1,0);
    add(2,0,0,MODE_BOUNCE,8'h01,1,0); add(2,1,0,MODE_BOUNCE,8'h01,1,0);
    add(2,1,0,MODE_BOUNCE,8'h02,1,0); add(2,1,0,MODE_BOUNCE,8'h02,1,0);
    add(2,1,0,MODE_BOUNCE,8'h02,1,0); add(2,1,0,MODE_BOUNCE,8'h02,1,0);
    add(2,1,0,MODE_BOUNCE,8'h04,1,0); add(2,1,0,MODE_HOLD,  8'h04,1,0);
    // Rotate-left to 80, then bounce clamps at the top end and turns.
    add(0,1,1,MODE_BOUNCE,8'h01,1,0);
    add(0,1,0,MODE_ROTL,  8'h02,1,0); add(0,1,0,MODE_ROTL,  8'h04,1,0);
    add(0,1,0,MODE_ROTL,  8'h08,1,0); add(0,1,0,MODE_ROTL,  8'h10,1,0);
    add(0,1,0,MODE_ROTL,  8'h20,1,0); add(0,1,0,MODE_ROTL,  8'h40,1,0);
    add(0,1,0,MODE_ROTL,  8'h80,1,0); add(0,1,0,MODE_BOUNCE,8'h80,0,1);
    add(0,1,0,MODE_BOUNCE,8'h40,0,0);

    reset = 1'b0;
    if_a.en = 1'b0; if_a.clr = 1'b0; if_a.mode = MODE_BOUNCE;
    if_b.en = 1'b0; if_b.clr = 1'b0; if_b.mode = MODE_BOUNCE;
    if_c.en = 1'b0; if_c.clr = 1'b0; if_c.mode = MODE_BOUNCE;
    repeat (2) @(posedge clk);
    #1;
    check("reset a counter", if_a.counter, 8'h01);
    check("reset b counter", if_b.counter, 8'h07);
    check("reset c counter", if_c.counter, 8'h01);
    check("reset a dir", {7'b0, if_a.dir}, 8'h01);
    check("reset a edge_hit", {7'b0, if_a.edge_hit}, 8'h00);
    @(negedge clk);
    reset = 1'b1;

    foreach (tbl[i]) apply(tbl[i]);

    // Asynchronous reset between edges while dut_a is mid-sweep (at 40, moving down).
    @(posedge clk);
    #3;
    reset = 1'b0;
    #1;
    check("async a counter", if_a.counter, 8'h01);
    check("async a dir", {7'b0, if_a.dir}, 8'h01);
    check("async b counter", if_b.counter, 8'h07);
    @(negedge clk);
    reset = 1'b1;

    // After release the first step needs PRESCALE enabled cycles.
    run1(2,1,0,MODE_BOUNCE,8'h01,1,0);
    run1(2,1,0,MODE_BOUNCE,8'h01,1,0);
    run1(2,1,0,MODE_BOUNCE,8'h01,1,0);
    run1(2,1,0,MODE_BOUNCE,8'h02,1,0);
    // clr mid-prescale restarts both pattern and prescaler.
    run1(2,1,0,MODE_BOUNCE,8'h02,1,0);
    run1(2,1,0,MODE_BOUNCE,8'h02,1,0);
    run1(2,1,1,MODE_BOUNCE,8'h01,1,0);
    run1(2,1,0,MODE_BOUNCE,8'h01,1,0);
    run1(2,1,0,MODE_BOUNCE,8'h01,1,0);
    run1(2,1,0,MODE_BOUNCE,8'h01,1,0);
    run1(2,1,0,MODE_BOUNCE,8'h02,1,0);

    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL scoreboard: %0d entries left, expected 0", exp_q.size());
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
